instruction_fetch_unit: RTL and testbench



---
 rtl/thinpad_pkg.sv | 35 +++
 rtl/instruction_fetch_unit_if.sv | 42 ++++
 rtl/instruction_fetch_unit_if_id_reg.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 111 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/thinpad_pkg.sv
// Shared definitions for the ThinPad fetch stage: reset/bubble constants,
// fetch controller states and the IF/ID pipeline bundle.
package thinpad_pkg;

    localparam logic [15:0] NOP_INSTR   = 16'b0000100000000000;
    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam logic [15:0] PC_STEP     = 16'd4;
    localparam int          BOOT_CYCLES = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // What the IF/ID register does on the next edge.
    typedef enum logic [1:0] {
        IFID_KEEP   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } if_id_op_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        valid;
    } if_id_t;

    // Next sequential fetch address; 16-bit modulo so the PC wraps at the top.
    function automatic logic [15:0] pc_advance(input logic [15:0] pc,
                                               input logic [15:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch stage's memory-side and ID-side signals.
// master: the fetch unit; slave: instruction memory plus ID stage.
interface instruction_fetch_unit_if;

    logic [15:0] pc;
    logic [15:0] Instruction;
    logic        MemConflict;
    logic        stall_id;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    modport master (
        output pc,
        output if_id_instr,
        output if_id_pc,
        output if_id_valid,
        output fetch_count,
        input  Instruction,
        input  MemConflict,
        input  stall_id,
        input  branch_taken,
        input  branch_target
    );

    modport slave (
        input  pc,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_valid,
        input  fetch_count,
        output Instruction,
        output MemConflict,
        output stall_id,
        output branch_taken,
        output branch_target
    );

endinterface

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds, loads a fetched word, or inserts a bubble
// tagged with the PC that was current when the bubble was created.
module if_id_reg
    import thinpad_pkg::if_id_t;
    import thinpad_pkg::if_id_op_t;
    import thinpad_pkg::IFID_KEEP;
    import thinpad_pkg::IFID_LOAD;
    import thinpad_pkg::IFID_BUBBLE;
#(
    parameter logic [15:0] RESET_PC  = thinpad_pkg::RESET_PC,
    parameter logic [15:0] NOP_INSTR = thinpad_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  if_id_op_t   op,
    input  logic [15:0] instr,
    input  logic [15:0] pc,
    output if_id_t      if_id_p1
);

    // Register update: reset to a bubble at RESET_PC, otherwise follow op.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_id_p1 <= '{instr: NOP_INSTR, pc: RESET_PC, valid: 1'b0};
        end else begin
            case (op)
                IFID_LOAD:   if_id_p1 <= '{instr: instr,     pc: pc, valid: 1'b1};
                IFID_BUBBLE: if_id_p1 <= '{instr: NOP_INSTR, pc: pc, valid: 1'b0};
                IFID_KEEP:   if_id_p1 <= if_id_p1;
                default:     if_id_p1 <= if_id_p1;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// First ThinPad pipeline stage: owns the PC, fetches from the combinational
// instruction memory, and resolves branch / stall / memory-conflict per cycle.
module instruction_fetch_unit
    import thinpad_pkg::fetch_state_t;
    import thinpad_pkg::BOOT;
    import thinpad_pkg::RUN;
    import thinpad_pkg::HOLD;
    import thinpad_pkg::if_id_t;
    import thinpad_pkg::if_id_op_t;
    import thinpad_pkg::IFID_KEEP;
    import thinpad_pkg::IFID_LOAD;
    import thinpad_pkg::IFID_BUBBLE;
    import thinpad_pkg::pc_advance;
#(
    parameter logic [15:0] RESET_PC    = thinpad_pkg::RESET_PC,
    parameter logic [15:0] PC_STEP     = thinpad_pkg::PC_STEP,
    parameter logic [15:0] NOP_INSTR   = thinpad_pkg::NOP_INSTR,
    parameter int          BOOT_CYCLES = thinpad_pkg::BOOT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);

    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);

    fetch_state_t   state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [15:0]    pc_q, pc_d;
    logic [15:0]    cnt_q, cnt_d;
    if_id_op_t      op;
    if_id_t         if_id_p1;
    logic           boot_done;

    assign boot_done = (boot_cnt_q >= BOOT_LAST);

    // Controller registers: state, boot counter, PC and delivered-count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            pc_q       <= RESET_PC;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and IF/ID control; branch > stall > conflict > normal fetch.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        op         = IFID_KEEP;
        case (state_q)
            BOOT: begin
                // Memory is still initialising: bubbles only, inputs ignored.
                op = IFID_BUBBLE;
                if (boot_done) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            RUN, HOLD: begin
                state_d = bus.MemConflict ? HOLD : RUN;
                if (bus.branch_taken) begin
                    // The wrong-path word at the current PC is squashed.
                    pc_d = bus.branch_target;
                    op   = IFID_BUBBLE;
                end else if (!bus.stall_id) begin
                    if (bus.MemConflict) begin
                        op = IFID_BUBBLE;
                    end else begin
                        op    = IFID_LOAD;
                        pc_d  = pc_advance(pc_q, PC_STEP);
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
                op      = IFID_BUBBLE;
            end
        endcase
    end

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .instr    (bus.Instruction),
        .pc       (pc_q),
        .if_id_p1 (if_id_p1)
    );

    assign bus.pc          = pc_q;
    assign bus.if_id_instr = if_id_p1.instr;
    assign bus.if_id_pc    = if_id_p1.pc;
    assign bus.if_id_valid = if_id_p1.valid;
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: behavioural fetch model checked every
// cycle, directed scenarios with literal expectations, and a random phase.
module tb_instruction_fetch_unit;

    localparam logic [15:0] NOP = 16'b0000100000000000;
    localparam int          BOOTN = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [15:0] mem [0:16383];

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.Instruction = mem[bus.pc[15:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_valid;
    int          m_boot;
    bit          m_live = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the fetch rules once per rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_pc = 16'h0000; m_instr = NOP; m_ipc = 16'h0000; m_valid = 1'b0;
            m_cnt = 16'h0000; m_boot = BOOTN; m_live = 1'b1;
        end else if (m_live) begin
            if (m_boot > 0) begin
                m_boot = m_boot - 1;
                m_instr = NOP; m_ipc = m_pc; m_valid = 1'b0;
            end else if (bus.branch_taken) begin
                m_instr = NOP; m_ipc = m_pc; m_valid = 1'b0;
                m_pc = bus.branch_target;
            end else if (bus.stall_id) begin
                // everything holds
            end else if (bus.MemConflict) begin
                m_instr = NOP; m_ipc = m_pc; m_valid = 1'b0;
            end else begin
                m_instr = mem[m_pc[15:2]]; m_ipc = m_pc; m_valid = 1'b1;
                m_pc = m_pc + 16'd4;
                m_cnt = m_cnt + 16'd1;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("pc",          bus.pc,                 m_pc);
            chk("if_id_instr", bus.if_id_instr,        m_instr);
            chk("if_id_pc",    bus.if_id_pc,           m_ipc);
            chk("if_id_valid", {15'd0, bus.if_id_valid}, {15'd0, m_valid});
            chk("fetch_count", bus.fetch_count,        m_cnt);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_in(input logic mc, input logic st, input logic br, input logic [15:0] tg);
        bus.MemConflict   = mc;
        bus.stall_id      = st;
        bus.branch_taken  = br;
        bus.branch_target = tg;
    endtask

    task automatic lit(input string tag, input logic [15:0] instr, input logic [15:0] ipc,
                       input logic valid, input logic [15:0] pc);
        chk({tag, ".instr"}, bus.if_id_instr, instr);
        chk({tag, ".ipc"},   bus.if_id_pc,    ipc);
        chk({tag, ".valid"}, {15'd0, bus.if_id_valid}, {15'd0, valid});
        chk({tag, ".pc"},    bus.pc,          pc);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] w2, w16, wtop;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h4A05;
        mem[1] = 16'hD844;
        w2   = mem[2];
        w16  = mem[16];
        wtop = mem[16383];

        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(); cyc();
        lit("reset", NOP, 16'h0000, 1'b0, 16'h0000);
        chk("reset.count", bus.fetch_count, 16'h0000);

        // Boot then free run
        rst = 1'b1;
        cyc(); lit("boot1", NOP, 16'h0000, 1'b0, 16'h0000);
        cyc(); lit("boot2", NOP, 16'h0000, 1'b0, 16'h0000);
        cyc(); lit("run0", 16'h4A05, 16'h0000, 1'b1, 16'h0004);
        cyc(); lit("run1", 16'hD844, 16'h0004, 1'b1, 16'h0008);
        chk("run1.count", bus.fetch_count, 16'd2);

        // Two conflict cycles at pc 8
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(); lit("conf1", NOP, 16'h0008, 1'b0, 16'h0008);
        cyc(); lit("conf2", NOP, 16'h0008, 1'b0, 16'h0008);
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(); lit("conf_rel", w2, 16'h0008, 1'b1, 16'h000C);
        chk("conf_rel.count", bus.fetch_count, 16'd3);

        // Stall for 3 cycles, conflict in the middle one
        set_in(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(); lit("stall1", w2, 16'h0008, 1'b1, 16'h000C);
        set_in(1'b1, 1'b1, 1'b0, 16'h0000);
        cyc(); lit("stall2", w2, 16'h0008, 1'b1, 16'h000C);
        set_in(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(); lit("stall3", w2, 16'h0008, 1'b1, 16'h000C);
        chk("stall.count", bus.fetch_count, 16'd3);

        // Branch overriding stall and conflict
        set_in(1'b1, 1'b1, 1'b1, 16'h0040);
        cyc(); lit("branch", NOP, 16'h000C, 1'b0, 16'h0040);
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(); lit("br_hold", NOP, 16'h0040, 1'b0, 16'h0040);
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(); lit("br_fetch", w16, 16'h0040, 1'b1, 16'h0044);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 9) == 0, 16'($urandom));
            cyc();
        end

        // Reset asserted while in HOLD
        rst = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc();
        rst = 1'b0;
        cyc(); lit("rst_hold", NOP, 16'h0000, 1'b0, 16'h0000);
        chk("rst_hold.count", bus.fetch_count, 16'h0000);
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 16'h1234);
        cyc(); lit("rboot1", NOP, 16'h0000, 1'b0, 16'h0000);
        cyc(); lit("rboot2", NOP, 16'h0000, 1'b0, 16'h0000);
        set_in(1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(); lit("rconf", NOP, 16'h0000, 1'b0, 16'h0000);
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(); lit("rrun", 16'h4A05, 16'h0000, 1'b1, 16'h0004);

        // PC wrap at the top of the address space
        set_in(1'b0, 1'b0, 1'b1, 16'hFFFC);
        cyc(); lit("wbr", NOP, 16'h0004, 1'b0, 16'hFFFC);
        set_in(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(); lit("wtop", wtop, 16'hFFFC, 1'b1, 16'h0000);
        cyc(); lit("wzero", 16'h4A05, 16'h0000, 1'b1, 16'h0004);

        // Free run until the delivered count wraps
        n = 0;
        while (m_cnt != 16'hFFFF && n < 70000) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 70000) begin
            errors++;
            $display("FAIL count_budget: ran %0d cycles, count %h expected ffff", n, bus.fetch_count);
        end
        chk("cnt_ffff", bus.fetch_count, 16'hFFFF);
        cyc();
        chk("cnt_wrap", bus.fetch_count, 16'h0000);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
